// File: rtl/blockram_req_pkg.sv
// Shared types for the block-RAM request controller and its response FIFO.
// Struct widths follow the default element width / depth below.
package blockram_req_pkg;

    localparam int ELEM_W_DEF      = 64;
    localparam int NUM_SETS_DEF    = 64;
    localparam int SET_W_DEF       = $clog2(NUM_SETS_DEF);
    localparam int RESP_FIFO_DEPTH = 2;
    localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  write;
        logic [SET_W_DEF-1:0]  addr;
        logic [ELEM_W_DEF-1:0] data;
    } req_t;

    typedef struct packed {
        logic [SET_W_DEF-1:0]  addr;
        logic [ELEM_W_DEF-1:0] data;
    } resp_t;

    typedef enum logic {
        CTRL_CLEAR,
        CTRL_READY
    } ctrl_state_e;

endpackage

// File: rtl/blockram_resp_fifo.sv
// Two-entry response buffer; head entry is visible combinationally.
module blockram_resp_fifo
    import blockram_req_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  push_i,
    input  resp_t                 push_data_i,
    input  logic                  pop_i,
    output resp_t                 head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [RESP_CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);

    resp_t                 mem_q [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [RESP_CNT_W-1:0] count_q;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == RESP_CNT_W'(RESP_FIFO_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + RESP_CNT_W'(do_push) - RESP_CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/blockram_request_controller.sv
// Valid/ready front end for single_port_blockram with a 2-credit read path.
// BLOCKRAM_REQ_CTRL_INIT_CLEAR_EN: zero-fill the RAM after reset before accepting traffic.
module blockram_request_controller
    import blockram_req_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = ELEM_W_DEF,
    parameter int NUMBER_SETS                 = NUM_SETS_DEF,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_in,
    input  logic                                   reset_n_in,
    input  logic                                   req_valid_in,
    output logic                                   req_ready_out,
    input  logic                                   req_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,
    output logic                                   resp_valid_out,
    input  logic                                   resp_ready_in,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_data_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       resp_addr_out,
    output logic                                   ram_access_en_out,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
    output logic                                   init_done_out
);

    req_t                              req;
    logic                              init_done, clearing;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]  clear_addr;
    logic                              in_flight_q;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]  rd_addr_q;
    logic                              accept, rd_accept, resp_pop;
    logic                              fifo_full, fifo_empty;
    logic [RESP_CNT_W-1:0]             fifo_count, occ, occ_after;
    resp_t                             fifo_in, fifo_head;

    assign req = '{write: req_write_in, addr: req_addr_in, data: req_data_in};

`ifdef BLOCKRAM_REQ_CTRL_INIT_CLEAR_EN
    ctrl_state_e                      state_q;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_ctr_q;
    logic                             init_done_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= CTRL_CLEAR;
            clear_ctr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                CTRL_CLEAR: begin
                    clear_ctr_q <= clear_ctr_q + 1'b1;
                    if (clear_ctr_q == SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1)) begin
                        state_q     <= CTRL_READY;
                        init_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done  = init_done_q;
    // Keep the RAM port quiet while reset is held even though the state is CLEAR.
    assign clearing   = reset_n_in && (state_q == CTRL_CLEAR);
    assign clear_addr = clear_ctr_q;
`else
    assign init_done  = 1'b1;
    assign clearing   = 1'b0;
    assign clear_addr = '0;
`endif

    assign init_done_out = init_done;

    // Credits: buffered responses plus the read whose data lands next cycle.
    assign occ       = fifo_full ? RESP_CNT_W'(RESP_FIFO_DEPTH)
                                 : fifo_count + RESP_CNT_W'(in_flight_q);
    assign resp_pop  = !fifo_empty && resp_ready_in;
    assign occ_after = occ - RESP_CNT_W'(resp_pop);

    assign req_ready_out = init_done && (req.write || occ_after < RESP_CNT_W'(RESP_FIFO_DEPTH));
    assign accept        = req_valid_in && req_ready_out;
    assign rd_accept     = accept && !req.write;

    always_comb begin
        ram_access_en_out     = 1'b0;
        ram_write_en_out      = 1'b0;
        ram_set_addr_out      = '0;
        ram_write_element_out = '0;
        if (clearing) begin
            ram_access_en_out = 1'b1;
            ram_write_en_out  = 1'b1;
            ram_set_addr_out  = clear_addr;
        end else if (accept) begin
            ram_access_en_out     = 1'b1;
            ram_write_en_out      = req.write;
            ram_set_addr_out      = req.addr;
            ram_write_element_out = req.data;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            in_flight_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            in_flight_q <= rd_accept;
            if (rd_accept) rd_addr_q <= req.addr;
        end
    end

    assign fifo_in = '{addr: rd_addr_q, data: ram_read_element_in};

    blockram_resp_fifo u_resp_fifo (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .push_i      (in_flight_q),
        .push_data_i (fifo_in),
        .pop_i       (resp_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign resp_valid_out = !fifo_empty;
    assign resp_data_out  = fifo_empty ? '0 : fifo_head.data;
    assign resp_addr_out  = fifo_empty ? '0 : fifo_head.addr;

endmodule

// File: tb/tb_blockram_request_controller.sv
// Directed bench: queue-based reference model, a RAM model and literal spot checks.
module tb_blockram_request_controller;

`ifdef BLOCKRAM_REQ_CTRL_INIT_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    localparam int NS = 64;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        req_valid_in = 1'b0, req_write_in = 1'b0, resp_ready_in = 1'b1;
    logic [5:0]  req_addr_in = '0;
    logic [63:0] req_data_in = '0;
    logic        req_ready_out, resp_valid_out, ram_access_en_out, ram_write_en_out, init_done_out;
    logic [63:0] resp_data_out, ram_write_element_out, ram_read_element_in;
    logic [5:0]  resp_addr_out, ram_set_addr_out;

    blockram_request_controller dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_write_in(req_write_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_data_out(resp_data_out), .resp_addr_out(resp_addr_out),
        .ram_access_en_out(ram_access_en_out), .ram_write_en_out(ram_write_en_out),
        .ram_set_addr_out(ram_set_addr_out), .ram_write_element_out(ram_write_element_out),
        .ram_read_element_in(ram_read_element_in), .init_done_out(init_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Single-port RAM: registered read, data valid the cycle after the access edge.
    logic [63:0] ram_mem [int];
    logic [63:0] ram_rd_q = '0;
    assign ram_read_element_in = ram_rd_q;
    always @(posedge clk_in) begin
        if (ram_access_en_out) begin
            if (ram_write_en_out) ram_mem[int'(ram_set_addr_out)] = ram_write_element_out;
            else ram_rd_q <= ram_mem.exists(int'(ram_set_addr_out)) ? ram_mem[int'(ram_set_addr_out)] : '1;
        end
    end

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: outstanding reads in accept order, plus a shadow of RAM contents.
    typedef struct { logic [5:0] a; logic [63:0] d; int cyc; } exp_t;
    exp_t        q[$];
    logic [63:0] shadow [int];
    logic [63:0] log_q[$];
    int          cyc = 0, since_rst = 0;
    logic        m_init, m_clr, m_valid, m_pop, m_ready, m_acc;

    always @(negedge clk_in) begin
        if (!reset_n_in) begin
            q.delete();
            since_rst = 0;
            chk("rst_resp_valid", resp_valid_out, 0);
            chk("rst_ram_en", ram_access_en_out, 0);
        end else begin
            m_init  = CLR_EN ? (since_rst >= NS) : 1'b1;
            m_clr   = !m_init;
            m_valid = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            chk("init_done", init_done_out, m_init);
            chk("resp_valid", resp_valid_out, m_valid);
            if (m_valid) begin
                chk("resp_data", resp_data_out, q[0].d);
                chk("resp_addr", resp_addr_out, q[0].a);
            end
            m_pop   = m_valid && resp_ready_in;
            m_ready = m_init && (req_write_in || (q.size() - int'(m_pop)) < 2);
            chk("req_ready", req_ready_out, m_ready);
            m_acc = !m_clr && req_valid_in && m_ready;
            chk("ram_en", ram_access_en_out, m_clr || m_acc);
            chk("ram_we", ram_write_en_out, m_clr || (m_acc && req_write_in));
            chk("ram_addr", ram_set_addr_out, m_clr ? since_rst : (m_acc ? req_addr_in : 0));
            chk("ram_wdata", ram_write_element_out, m_acc ? req_data_in : 0);
            if (m_pop) begin
                log_q.push_back(resp_data_out);
                void'(q.pop_front());
            end
            if (m_clr) shadow[since_rst] = '0;
            else if (m_acc) begin
                if (req_write_in) shadow[int'(req_addr_in)] = req_data_in;
                else q.push_back('{req_addr_in,
                        shadow.exists(int'(req_addr_in)) ? shadow[int'(req_addr_in)] : '1, cyc});
            end
            since_rst++;
        end
        cyc++;
    end

    int stalls = 0, acc_cnt = 0;

    task automatic do_req(input logic w, input logic [5:0] a, input logic [63:0] d);
        bit done = 1'b0;
        req_valid_in = 1'b1; req_write_in = w; req_addr_in = a; req_data_in = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_in);
            done = req_ready_out;
            if (!done) stalls++;
            @(posedge clk_in); #1;
        end
        chk("req_accepted", done, 1);
        if (done) acc_cnt++;
        req_valid_in = 1'b0; req_write_in = 1'b0; req_addr_in = '0; req_data_in = '0;
    endtask

    task automatic wait_init();
        int k = 0;
        @(negedge clk_in);
        while (!init_done_out && k < 300) begin
            @(negedge clk_in);
            k++;
        end
        chk("init_latency", k, CLR_EN ? NS : 0);
        @(posedge clk_in); #1;
    endtask

    task automatic drain();
        resp_ready_in = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            @(posedge clk_in); #1;
        end
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        int s0, base, a0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid_lit", resp_valid_out, 0);
        chk("rst_data_lit", resp_data_out, 0);
        chk("rst_ram_en_lit", ram_access_en_out, 0);
        chk("rst_init_lit", init_done_out, CLR_EN ? 0 : 1);
        reset_n_in = 1'b1;
        wait_init();

`ifdef BLOCKRAM_REQ_CTRL_INIT_CLEAR_EN
        base = log_q.size();
        do_req(0, 0, 0); do_req(0, 37, 0); do_req(0, 63, 0);
        drain();
        chk("clear_rd_cnt", log_q.size() - base, 3);
        chk("clear_rd0", log_q[base], 0);
        chk("clear_rd63", log_q[base+2], 0);
`endif

        for (int a = 0; a < NS; a++) do_req(1, 6'(a), 64'(a * 3));
        s0 = stalls; base = log_q.size();
        for (int a = 0; a < NS; a++) do_req(0, 6'(a), 0);
        drain();
        chk("stream_stalls", stalls - s0, 0);
        chk("stream_cnt", log_q.size() - base, 64);
        chk("stream_rd10", log_q[base+10], 30);
        chk("stream_rd63", log_q[base+63], 189);

        resp_ready_in = 1'b0; a0 = acc_cnt; base = log_q.size();
        fork
            begin
                for (int a = 1; a <= 4; a++) do_req(0, 6'(a), 0);
            end
            begin
                repeat (6) @(negedge clk_in);
                chk("bp_accepted", acc_cnt - a0, 2);
                chk("bp_ready_low", req_ready_out, 0);
                chk("bp_valid_held", resp_valid_out, 1);
                @(posedge clk_in); #1;
                resp_ready_in = 1'b1;
            end
        join
        drain();
        chk("bp_cnt", log_q.size() - base, 4);
        chk("bp_rd1", log_q[base], 3);
        chk("bp_rd4", log_q[base+3], 12);

        base = log_q.size();
        do_req(1, 5, 64'hDEAD);
        do_req(0, 5, 0);
        do_req(0, 5, 0);
        do_req(1, 5, 64'hBEEF);
        do_req(0, 5, 0);
        drain();
        chk("raw_data", log_q[base], 64'hDEAD);
        chk("war_data", log_q[base+1], 64'hDEAD);
        chk("after_war", log_q[base+2], 64'hBEEF);

        resp_ready_in = 1'b0; base = log_q.size();
        do_req(0, 7, 0); do_req(0, 8, 0);
        s0 = stalls;
        for (int i = 0; i < 3; i++) do_req(1, 6'(20 + i), 64'h100 + 64'(i));
        chk("full_wr_stalls", stalls - s0, 0);
        @(negedge clk_in);
        chk("full_valid", resp_valid_out, 1);
        chk("full_head_addr", resp_addr_out, 7);
        @(posedge clk_in); #1;
        drain();
        do_req(0, 21, 0);
        drain();
        chk("full_rd7", log_q[base], 21);
        chk("full_rd8", log_q[base+1], 24);
        chk("full_wr21", log_q[base+2], 64'h101);

        resp_ready_in = 1'b0;
        do_req(0, 9, 0);
        do_req(0, 10, 0);
        chk("pre_rst_valid", resp_valid_out, 1);
        reset_n_in = 1'b0;
        #1;
        chk("async_clear", resp_valid_out, 0);
        repeat (2) @(posedge clk_in);
        #1;
        reset_n_in = 1'b1; resp_ready_in = 1'b1; base = log_q.size();
        wait_init();
        repeat (10) @(posedge clk_in);
        #1;
        chk("no_stale", log_q.size() - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d, expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
